multicycle_alu: RTL and testbench

//  Parametrised successor to the single-bit ALU slice: WIDTH-bit ALU that reuses one

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_slice_n.sv | 37 +++
 rtl/multicycle_alu.sv | 125 ++++++++++++
 tb/tb_multicycle_alu.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - funct codes, FSM states and op decode shared by the multicycle ALU
package alu_pkg;

  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_NOR = 6'd39;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_SLT = 6'd42;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef enum logic [1:0] {OP_AND, OP_OR, OP_NOR, OP_ADD} op_t;

  // legal: funct recognised; invb: feed ~b and carry-in 1 (SUB/SLT);
  // arith: carry flag meaningful; ovf_en: overflow flag meaningful (ADD/SUB)
  typedef struct packed {
    logic legal;
    op_t  op;
    logic invb;
    logic slt;
    logic arith;
    logic ovf_en;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] fn);
    dec_t d;
    d = '0;
    case (fn)
      FN_AND: begin d.legal = 1'b1; d.op = OP_AND; end
      FN_OR:  begin d.legal = 1'b1; d.op = OP_OR;  end
      FN_NOR: begin d.legal = 1'b1; d.op = OP_NOR; end
      FN_ADD: begin d.legal = 1'b1; d.op = OP_ADD; d.arith = 1'b1; d.ovf_en = 1'b1; end
      FN_SUB: begin
        d.legal = 1'b1; d.op = OP_ADD; d.invb = 1'b1; d.arith = 1'b1; d.ovf_en = 1'b1;
      end
      FN_SLT: begin
        d.legal = 1'b1; d.op = OP_ADD; d.invb = 1'b1; d.arith = 1'b1; d.slt = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_slice_n.sv
// rtl/alu_slice_n.sv - combinational SLICE_W-bit ALU slice with carry in/out
module alu_slice_n
  import alu_pkg::*;
#(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               invb,
  input  logic               cin,
  input  op_t                op,
  output logic [SLICE_W-1:0] y,
  output logic               cout,
  output logic               cin_msb
);

  logic [SLICE_W-1:0] bx;
  logic [SLICE_W:0]   sum;

  assign bx   = invb ? ~b : b;
  assign sum  = {1'b0, a} + {1'b0, bx} + {{SLICE_W{1'b0}}, cin};
  assign cout = sum[SLICE_W];
  // sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out directly
  assign cin_msb = sum[SLICE_W-1] ^ a[SLICE_W-1] ^ bx[SLICE_W-1];

  // Select logic or adder output for this slice
  always_comb begin
    y = sum[SLICE_W-1:0];
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOR:  y = ~(a | b);
      default: y = sum[SLICE_W-1:0];
    endcase
  end

endmodule

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - WIDTH-bit ALU iterating one SLICE_W slice per cycle
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             err
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic               creg;
  logic [WIDTH-1:0]   a_r, b_r, work, res_nx;
  dec_t               dec_r, dec_in;
  logic               last, ovf_nx;
  logic [SLICE_W-1:0] y;
  logic               cout, cin_msb;

  assign dec_in    = decode(ctl);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last      = (cnt == LAST);
  assign ovf_nx    = cin_msb ^ cout;

  alu_slice_n #(.SLICE_W(SLICE_W)) u_slice (
    .a       (a_r[cnt*SLICE_W +: SLICE_W]),
    .b       (b_r[cnt*SLICE_W +: SLICE_W]),
    .invb    (dec_r.invb),
    .cin     (creg),
    .op      (dec_r.op),
    .y       (y),
    .cout    (cout),
    .cin_msb (cin_msb)
  );

  // Final result as it will look once the current slice is merged in
  always_comb begin
    res_nx = work;
    res_nx[cnt*SLICE_W +: SLICE_W] = y;
    if (dec_r.slt) res_nx = {{(WIDTH-1){1'b0}}, y[SLICE_W-1] ^ ovf_nx};
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next state: illegal funct skips RUN
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = dec_in.legal ? RUN : DONE;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, slice iteration and result/flag publication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      dec_r    <= '0;
      cnt      <= '0;
      creg     <= 1'b0;
      work     <= '0;
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= a;
          b_r   <= b;
          dec_r <= dec_in;
          cnt   <= '0;
          creg  <= dec_in.invb;
          if (!dec_in.legal) begin
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            err      <= 1'b1;
          end
        end
        RUN: begin
          work[cnt*SLICE_W +: SLICE_W] <= y;
          creg <= cout;
          cnt  <= cnt + 1'b1;
          if (last) begin
            result   <= res_nx;
            zero     <= (res_nx == '0);
            carry    <= dec_r.arith & cout;
            overflow <= dec_r.ovf_en & ovf_nx;
            err      <= ~dec_r.legal;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - scoreboard bench for multicycle_alu (32/8 and 16/16)
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [5:0]  ctl;
  logic [31:0] a, b, result;
  logic        zero, carry, overflow, err;

  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [5:0]  ctl2;
  logic [15:0] a2, b2, result2;
  logic        zero2, carry2, overflow2, err2;

  always #5 clk = ~clk;

  multicycle_alu #(.WIDTH(32), .SLICE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .ctl(ctl),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .carry(carry), .overflow(overflow), .err(err)
  );

  multicycle_alu #(.WIDTH(16), .SLICE_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .ctl(ctl2),
    .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2), .result(result2),
    .zero(zero2), .carry(carry2), .overflow(overflow2), .err(err2)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        z, c, o, e;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_res;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [32:0] s;
    e = '0;
    s = '0;
    case (f)
      6'd36: e.res = x & y;
      6'd37: e.res = x | y;
      6'd39: e.res = ~(x | y);
      6'd32: begin
        s = {1'b0, x} + {1'b0, y};
        e.res = s[31:0]; e.c = s[32];
        e.o = (x[31] == y[31]) && (s[31] != x[31]);
      end
      6'd34: begin
        s = {1'b0, x} + {1'b0, ~y} + 33'd1;
        e.res = s[31:0]; e.c = s[32];
        e.o = (x[31] != y[31]) && (s[31] != x[31]);
      end
      6'd42: begin
        s = {1'b0, x} + {1'b0, ~y} + 33'd1;
        e.c = s[32];
        e.res = {31'd0, ($signed(x) < $signed(y))};
      end
      default: e.e = 1'b1;
    endcase
    if (!e.e) e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic start_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    chk("in_ready_before_op", in_ready, 1);
    ctl = f; a = x; b = y; in_valid = 1'b1;
    sb.push_back(model(f, x, y));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~x; b = $urandom; ctl = 6'($urandom);
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int   lat;
    exp_t e;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    if (sb.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_result"}, result, e.res);
      chk({tag, "_zero"}, zero, e.z);
      chk({tag, "_carry"}, carry, e.c);
      chk({tag, "_overflow"}, overflow, e.o);
      chk({tag, "_err"}, err, e.e);
      last_res = e.res;
    end
  endtask

  task automatic release_result(input int hold);
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_result", result, last_res);
      chk("hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [5:0] fns [6];
    fns = '{6'd32, 6'd34, 6'd42, 6'd36, 6'd37, 6'd39};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ctl = '0; a = '0; b = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; ctl2 = '0; a2 = '0; b2 = '0;
    last_res = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_flags", {zero, carry, overflow, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    start_op(6'd32, 32'hFFFFFFFF, 32'h00000001); wait_result("add_wrap", 4); release_result(0);
    start_op(6'd34, 32'h80000000, 32'h00000001); wait_result("sub_ovf", 4);  release_result(0);
    start_op(6'd42, 32'hFFFFFFFF, 32'h00000001); wait_result("slt_neg", 4);  release_result(0);
    start_op(6'd42, 32'h00000005, 32'hFFFFFFFB); wait_result("slt_ge", 4);   release_result(0);
    start_op(6'd36, 32'hF0F0F0F0, 32'hFF00FF00); wait_result("and", 4);      release_result(0);
    start_op(6'd39, 32'hF0F0F0F0, 32'hFF00FF00); wait_result("nor", 4);      release_result(0);
    for (int i = 0; i < 6; i++) begin
      start_op(fns[i], $urandom, $urandom); wait_result("rand", 4); release_result(1);
    end

    // illegal funct, result held under back-pressure while extra in_valid is offered
    start_op(6'd63, 32'h12345678, 32'h9ABCDEF0); wait_result("illegal", 0);
    @(negedge clk);
    in_valid = 1'b1; ctl = 6'd32; a = 32'd1; b = 32'd1;
    release_result(5);
    @(posedge clk);
    #1;
    chk("extra_in_valid_ignored", out_valid, 0);
    chk("scoreboard_drained", sb.size(), 0);

    // reset asserted in the second RUN cycle
    start_op(6'd37, 32'hF0F0F0F0, 32'hFF00FF00); wait_result("or", 4); release_result(0);
    start_op(6'd32, 32'h11111111, 32'h22222222);
    @(posedge clk);
    #2;
    chk("midrun_busy", in_ready, 0);
    chk("midrun_result_held", result, last_res);
    rst_n = 1'b0;
    #1;
    chk("abort_result", result, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_flags", {zero, carry, overflow, err}, 0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    start_op(6'd34, 32'd5, 32'd9); wait_result("post_reset_sub", 4); release_result(0);

    // single-slice instance: 16-bit ADD with signed overflow, one cycle
    @(negedge clk);
    ctl2 = 6'd32; a2 = 16'h7FFF; b2 = 16'h0001; in_valid2 = 1'b1; out_ready2 = 1'b1;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    chk("w16_not_yet_valid", out_valid2, 0);
    @(posedge clk);
    #1;
    chk("w16_out_valid", out_valid2, 1);
    chk("w16_result", result2, 32'h8000);
    chk("w16_overflow", overflow2, 1);
    chk("w16_carry_zero_err", {carry2, zero2, err2}, 0);
    @(posedge clk);
    #1;
    chk("w16_released", {out_valid2, in_ready2}, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
